// File: rtl/program_sequencer.sv
// Fetch/execute engine for the glitch-stimulus program ROM: serial byte sends, pin updates, delays.
// Optional PROG_SEQ_ABORT_EN adds an abort input that returns a running program to IDLE.
module program_sequencer #(
    parameter int unsigned PROG_LEN = 14,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef PROG_SEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic [7:0]  instr_pt,
    input  logic [11:0] instr,
    output logic [7:0]  delay_num,
    input  logic [31:0] delay_len,
    output logic        sdo,
    output logic        sclk,
    output logic [7:0]  pins,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_PINS,
        S_DELAY,
        S_DONE
    } state_t;

    localparam logic [1:0]  OP_SEND  = 2'b00;
    localparam logic [1:0]  OP_PINS  = 2'b01;
    localparam logic [1:0]  OP_HALT  = 2'b11;
    localparam logic [7:0]  PTR_END  = 8'(PROG_LEN);
    localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [7:0]  ptr_n, dnum_n;
    logic [7:0]  ir_opnd, opnd_n;
    logic        sdo_n, sclk_n;
    logic [7:0]  pins_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [31:0] div_cnt, div_n;
    logic [31:0] dly_cnt, dly_n;
    logic        dly_first, first_n;
    logic        exec_done;
    logic        unused_instr_lsb;

    assign unused_instr_lsb = instr[0];

    assign busy = (state == S_FETCH) || (state == S_SEND) ||
                  (state == S_PINS)  || (state == S_DELAY);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            instr_pt  <= '0;
            delay_num <= '0;
            ir_opnd   <= '0;
            sdo       <= 1'b0;
            sclk      <= 1'b0;
            pins      <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            dly_cnt   <= '0;
            dly_first <= 1'b0;
        end else begin
            state     <= state_n;
            instr_pt  <= ptr_n;
            delay_num <= dnum_n;
            ir_opnd   <= opnd_n;
            sdo       <= sdo_n;
            sclk      <= sclk_n;
            pins      <= pins_n;
            bit_cnt   <= bit_n;
            div_cnt   <= div_n;
            dly_cnt   <= dly_n;
            dly_first <= first_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = instr_pt;
        dnum_n    = delay_num;
        opnd_n    = ir_opnd;
        sdo_n     = sdo;
        sclk_n    = sclk;
        pins_n    = pins;
        bit_n     = bit_cnt;
        div_n     = div_cnt;
        dly_n     = dly_cnt;
        first_n   = dly_first;
        exec_done = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_FETCH;
                    ptr_n   = '0;
                end
            end
            S_FETCH: begin
                if (instr_pt == PTR_END || !instr[9] || instr[11:10] == OP_HALT) begin
                    state_n = S_DONE;
                end else begin
                    opnd_n = instr[8:1];
                    bit_n  = '0;
                    div_n  = '0;
                    case (instr[11:10])
                        OP_SEND: begin
                            // MSB is presented during FETCH so it is valid on the first SEND cycle
                            state_n = S_SEND;
                            sdo_n   = instr[8];
                            sclk_n  = 1'b0;
                        end
                        OP_PINS: state_n = S_PINS;
                        default: begin
                            state_n = S_DELAY;
                            dnum_n  = instr[8:1];
                            first_n = 1'b1;
                        end
                    endcase
                end
            end
            S_SEND: begin
                // sclk doubles as the half-period phase flag; ir_opnd shifts so [7] is the current bit
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n = 1'b0;
                        if (bit_cnt == 3'd7) begin
                            exec_done = 1'b1;
                        end else begin
                            bit_n  = bit_cnt + 3'd1;
                            opnd_n = {ir_opnd[6:0], 1'b0};
                            sdo_n  = ir_opnd[6];
                        end
                    end
                end else begin
                    div_n = div_cnt + 32'd1;
                end
            end
            S_PINS: begin
                pins_n    = ir_opnd;
                exec_done = 1'b1;
            end
            S_DELAY: begin
                first_n = 1'b0;
                // first cycle loads the remaining count after itself; lengths 0 and 1 finish here
                if (dly_first) begin
                    if (delay_len <= 32'd1) exec_done = 1'b1;
                    else                    dly_n     = delay_len - 32'd2;
                end else if (dly_cnt == '0) begin
                    exec_done = 1'b1;
                end else begin
                    dly_n = dly_cnt - 32'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (exec_done) begin
            state_n = S_FETCH;
            ptr_n   = instr_pt + 8'd1;
        end

`ifdef PROG_SEQ_ABORT_EN
        if (abort && busy) begin
            state_n = S_IDLE;
            sdo_n   = 1'b0;
            sclk_n  = 1'b0;
            pins_n  = '0;
        end
`endif
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a ROM model feeds the DUT, a monitor checks bytes and pin updates.
module tb_program_sequencer;

    localparam int unsigned TB_PROG_LEN = 14;
    localparam int unsigned TB_CLK_DIV  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
`ifdef PROG_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic [7:0]  instr_pt;
    logic [11:0] instr;
    logic [7:0]  delay_num;
    logic [31:0] delay_len;
    logic        sdo, sclk, busy, done;
    logic [7:0]  pins;

    logic [11:0] rom     [256];
    logic [31:0] dly_rom [256];

    assign instr     = rom[instr_pt];
    assign delay_len = dly_rom[delay_num];

    program_sequencer #(
        .PROG_LEN (TB_PROG_LEN),
        .CLK_DIV  (TB_CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef PROG_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .instr_pt  (instr_pt),
        .instr     (instr),
        .delay_num (delay_num),
        .delay_len (delay_len),
        .sdo       (sdo),
        .sclk      (sclk),
        .pins      (pins),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0] sb_bytes [$];
    logic [7:0] sb_pins  [$];
    logic [7:0] model_pins = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk(input logic [1:0] op, input logic v, input logic [7:0] opnd);
        return {op, v, opnd, 1'b0};
    endfunction

    function automatic int unsigned exp_cycles(input logic [11:0] w);
        case (w[11:10])
            2'b00:   return 1 + 16 * TB_CLK_DIV;
            2'b01:   return 2;
            default: return 1 + ((dly_rom[w[8:1]] == 0) ? 1 : dly_rom[w[8:1]]);
        endcase
    endfunction

    task automatic step;
        @(negedge clk);
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 256; i++) begin
            rom[i]     = 12'h000;
            dly_rom[i] = 32'd0;
        end
    endtask

    // expected bytes and pin changes for one run from pointer 0
    task automatic push_program;
        logic [11:0] w;
        for (int unsigned k = 0; k < TB_PROG_LEN; k++) begin
            w = rom[k];
            if (!w[9] || w[11:10] == 2'b11) break;
            if (w[11:10] == 2'b00) sb_bytes.push_back(w[8:1]);
            else if (w[11:10] == 2'b01 && w[8:1] != model_pins) begin
                sb_pins.push_back(w[8:1]);
                model_pins = w[8:1];
            end
        end
    endtask

    task automatic wait_ptr(input logic [7:0] target, input int unsigned budget, output int unsigned n);
        n = 0;
        while (instr_pt != target && n < budget) begin
            step;
            n++;
        end
    endtask

    task automatic wait_done(input int unsigned budget, output int unsigned n);
        n = 0;
        while (!done && n < budget) begin
            step;
            n++;
        end
    endtask

    // monitor: reassemble bytes on sclk rising edges and detect pin changes
    logic        mon_prev_sclk = 1'b0;
    logic [7:0]  mon_shift = 8'h00;
    int unsigned mon_bits = 0;
    logic [7:0]  mon_prev_pins = 8'h00;

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            mon_bits      = 0;
            mon_prev_sclk = 1'b0;
            mon_prev_pins = pins;
        end else begin
            if (sclk && !mon_prev_sclk) begin
                mon_shift = {mon_shift[6:0], sdo};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    e = (sb_bytes.size() > 0) ? sb_bytes.pop_front() : ~mon_shift;
                    check("sb_byte", {24'h0, mon_shift}, {24'h0, e});
                end
            end
            mon_prev_sclk = sclk;
            if (pins != mon_prev_pins) begin
                e = (sb_pins.size() > 0) ? sb_pins.pop_front() : ~pins;
                check("sb_pins", {24'h0, pins}, {24'h0, e});
                mon_prev_pins = pins;
            end
        end
    end

    initial begin
        int unsigned n;
        int unsigned dn_bad;
        logic [7:0]  b;

        clear_rom;
        repeat (3) step;
        check("rst_outputs", {instr_pt, delay_num, pins, 4'(0), sdo, sclk, busy, done}, 32'h0);
        rst_n = 1'b1;
        step;
        check("idle_busy", {31'h0, busy}, 32'h0);

        // program 1: full 14-instruction run
        rom[0]  = mk(2'b00, 1'b1, 8'h84);
        rom[1]  = mk(2'b01, 1'b1, 8'hF2);
        rom[2]  = mk(2'b10, 1'b1, 8'h00);
        rom[3]  = mk(2'b00, 1'b1, 8'h3C);
        rom[4]  = mk(2'b10, 1'b1, 8'h01);
        rom[5]  = mk(2'b01, 1'b1, 8'h55);
        rom[6]  = mk(2'b00, 1'b1, 8'hA5);
        rom[7]  = mk(2'b10, 1'b1, 8'h02);
        rom[8]  = mk(2'b00, 1'b1, 8'hFF);
        rom[9]  = mk(2'b01, 1'b1, 8'h00);
        rom[10] = mk(2'b00, 1'b1, 8'h01);
        rom[11] = mk(2'b01, 1'b1, 8'h80);
        rom[12] = mk(2'b10, 1'b1, 8'h03);
        rom[13] = mk(2'b00, 1'b1, 8'h7E);
        dly_rom[0] = 32'h1F40;
        dly_rom[1] = 32'd0;
        dly_rom[2] = 32'd3;
        dly_rom[3] = 32'd2;
        push_program;

        start = 1'b1;
        step;
        start = 1'b0;
        check("fetch0", {instr_pt, 6'h0, busy, done}, {8'h00, 6'h0, 1'b1, 1'b0});

        b = 8'h84;
        for (int j = 0; j < 16; j++) begin
            step;
            check($sformatf("send0_c%0d", j), {30'h0, sclk, sdo}, {30'h0, 1'(j % 2), b[7 - j / 2]});
        end
        step;
        check("ptr_after_send", {24'h0, instr_pt}, 32'd1);
        check("pins_at_fetch", {24'h0, pins}, 32'h00);
        step;
        check("pins_in_exec", {23'h0, busy, pins}, {23'h0, 1'b1, 8'h00});
        step;
        check("pins_f2", {23'h0, busy, pins}, {23'h0, 1'b1, 8'hF2});
        check("ptr2", {24'h0, instr_pt}, 32'd2);

        n = 0;
        dn_bad = 0;
        while (instr_pt != 8'd3 && n < 9000) begin
            step;
            n++;
            if (delay_num != 8'd0 || !busy) dn_bad++;
        end
        check("delay8000_cycles", n, 32'd8001);
        check("delay_num_held", dn_bad, 32'd0);

        for (int k = 3; k < 14; k++) begin
            wait_ptr(8'(k + 1), exp_cycles(rom[k]) + 50, n);
            check($sformatf("dur%0d", k), n, exp_cycles(rom[k]));
        end
        check("end_fetch", {30'h0, busy, done}, {30'h0, 1'b1, 1'b0});
        step;
        check("end_done", {instr_pt, 6'h0, busy, done}, {8'd14, 6'h0, 1'b0, 1'b1});
        repeat (3) step;
        check("done_hold", {pins, delay_num, 7'h0, done}, {8'h80, 8'h03, 7'h0, 1'b1});

        // program 2: invalid word at pointer 2, start held high restarts from DONE
        clear_rom;
        rom[0] = mk(2'b01, 1'b1, 8'h11);
        rom[1] = mk(2'b10, 1'b1, 8'h01);
        rom[2] = mk(2'b00, 1'b0, 8'hAA);
        push_program;
        start = 1'b1;
        step;
        wait_done(100, n);
        check("inv_cycles", n, 32'd5);
        check("inv_ptr", {instr_pt, 7'h0, busy}, {8'd2, 7'h0, 1'b0});
        step;
        check("restart", {instr_pt, 6'h0, busy, done}, {8'd0, 6'h0, 1'b1, 1'b0});
        start = 1'b0;
        wait_done(100, n);
        repeat (3) step;
        check("inv_hold", {instr_pt, 7'h0, done}, {8'd2, 7'h0, 1'b1});

        // program 3: HALT at pointer 2
        clear_rom;
        rom[0] = mk(2'b00, 1'b1, 8'h5A);
        rom[1] = mk(2'b01, 1'b1, 8'h22);
        rom[2] = mk(2'b11, 1'b1, 8'h33);
        push_program;
        start = 1'b1;
        step;
        start = 1'b0;
        wait_done(200, n);
        check("halt_cycles", n, 32'd20);
        check("halt_ptr_pins", {instr_pt, pins}, {8'd2, 8'h22});

`ifdef PROG_SEQ_ABORT_EN
        clear_rom;
        rom[0] = mk(2'b01, 1'b1, 8'hF2);
        rom[1] = mk(2'b10, 1'b1, 8'h00);
        rom[2] = mk(2'b00, 1'b1, 8'h84);
        dly_rom[0] = 32'h1F40;
        push_program;
        start = 1'b1;
        step;
        start = 1'b0;
        wait_ptr(8'd1, 50, n);
        repeat (100) step;
        abort = 1'b1;
        sb_bytes.delete();
        sb_pins.push_back(8'h00);
        model_pins = 8'h00;
        step;
        abort = 1'b0;
        check("abort_idle", {pins, 4'h0, sdo, sclk, busy, done}, 16'h0);
        repeat (2) step;
        check("abort_stay", {31'h0, busy}, 32'h0);
        push_program;
        start = 1'b1;
        step;
        start = 1'b0;
        check("abort_rerun", {instr_pt, 7'h0, busy}, {8'd0, 7'h0, 1'b1});
        wait_done(9000, n);
        check("abort_rerun_done", {instr_pt, 7'h0, done}, {8'd3, 7'h0, 1'b1});
`endif

        // asynchronous reset in the middle of a SEND
        clear_rom;
        rom[0] = mk(2'b00, 1'b1, 8'h0F);
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (10) step;
        check("pre_reset_bit3", {30'h0, sclk, sdo}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset", {instr_pt, delay_num, pins, 4'(0), sdo, sclk, busy, done}, 32'h0);
        model_pins = 8'h00;
        repeat (2) step;
        rst_n = 1'b1;
        repeat (4) step;
        check("post_reset_idle", {pins, 6'h0, sclk, busy}, 16'h0);

        check("sb_bytes_left", sb_bytes.size(), 32'd0);
        check("sb_pins_left", sb_pins.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
